// File: rtl/txstream_pkg.sv
// rtl/txstream_pkg.sv - shared types and constants for the TX IQ stream parser
package txstream_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEQ_NR,
        ST_I2,
        ST_I1,
        ST_I0,
        ST_Q2,
        ST_Q1,
        ST_Q0,
        ST_DRAIN
    } state_t;

    localparam logic [10:0] PAYLOAD_LEN      = 11'd1030;
    localparam int          SAMPLES_PER_PKT  = 171;
    localparam int          BYTES_PER_SAMPLE = 6;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/txstream.sv
// rtl/txstream.sv - UDP payload parser assembling 48-bit TX IQ samples for the modulator fifo
// Optional sequence-number checking is enabled with `define SEQ_CHECK_EN.
module txstream
    import txstream_pkg::*;
#(
    parameter logic [15:0] TX_PORT     = 16'd1025,
    parameter logic [10:0] PAYLOAD_LEN = 11'd1030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        have_ip,
    input  logic        udp_rx_active,
    input  logic [7:0]  udp_rx_data,
    input  logic [15:0] udp_to_port,
    output logic [47:0] tx_data,
    output logic        tx_wrreq,
    input  logic        tx_wrfull,
    output logic [31:0] seq_no,
    output logic [15:0] overflow_cnt
`ifdef SEQ_CHECK_EN
    ,
    output logic [15:0] seq_err_cnt
`endif
);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [47:0] asm_q, asm_d;
    logic [47:0] tx_data_q, tx_data_d;
    logic        tx_wrreq_q, tx_wrreq_d;
    logic [31:0] seq_no_q, seq_no_d;
    logic [15:0] ovf_q, ovf_d;
    logic        seq_latch;

    logic        enabled;
    logic        accept;
    logic [47:0] shifted;
    logic [10:0] cnt_inc;

    assign enabled = run & have_ip;
    assign accept  = udp_rx_active & enabled & (udp_to_port == TX_PORT);
    assign shifted = {asm_q[39:0], udp_rx_data};
    assign cnt_inc = cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        tx_data_d  = tx_data_q;
        tx_wrreq_d = 1'b0;
        seq_no_d   = seq_no_q;
        ovf_d      = ovf_q;
        seq_latch  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 11'd0;
                if (accept) begin
                    asm_d   = shifted;
                    cnt_d   = 11'd1;
                    state_d = ST_SEQ_NR;
                end else if (udp_rx_active) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = 11'd0;
                if (!udp_rx_active) state_d = ST_IDLE;
            end
            default: begin
                // An early end drops any partial sample; losing run/IP mid-packet drains the rest.
                if (!udp_rx_active) begin
                    cnt_d   = 11'd0;
                    state_d = ST_IDLE;
                end else if (!enabled) begin
                    state_d = ST_DRAIN;
                end else begin
                    asm_d = shifted;
                    cnt_d = cnt_inc;
                    case (state_q)
                        ST_SEQ_NR: begin
                            if (cnt_q == 11'd3) begin
                                seq_no_d  = shifted[31:0];
                                seq_latch = 1'b1;
                                state_d   = ST_I2;
                            end
                        end
                        ST_I2: state_d = ST_I1;
                        ST_I1: state_d = ST_I0;
                        ST_I0: state_d = ST_Q2;
                        ST_Q2: state_d = ST_Q1;
                        ST_Q1: state_d = ST_Q0;
                        ST_Q0: begin
                            if (!tx_wrfull) begin
                                tx_data_d  = shifted;
                                tx_wrreq_d = 1'b1;
                            end else begin
                                ovf_d = sat_inc16(ovf_q);
                            end
                            state_d = (cnt_inc < PAYLOAD_LEN) ? ST_I2 : ST_DRAIN;
                        end
                        default: state_d = ST_DRAIN;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 11'd0;
            asm_q      <= 48'd0;
            tx_data_q  <= 48'd0;
            tx_wrreq_q <= 1'b0;
            seq_no_q   <= 32'd0;
            ovf_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            tx_data_q  <= tx_data_d;
            tx_wrreq_q <= tx_wrreq_d;
            seq_no_q   <= seq_no_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_wrreq     = tx_wrreq_q;
    assign seq_no       = seq_no_q;
    assign overflow_cnt = ovf_q;

`ifdef SEQ_CHECK_EN
    logic [31:0] exp_seq_q;
    logic        exp_valid_q;
    logic [15:0] seq_err_q;

    // The first packet after run rises only seeds the expected value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_seq_q   <= 32'd0;
            exp_valid_q <= 1'b0;
            seq_err_q   <= 16'd0;
        end else if (!run) begin
            exp_valid_q <= 1'b0;
        end else if (seq_latch) begin
            if (exp_valid_q && (seq_no_d != exp_seq_q)) seq_err_q <= sat_inc16(seq_err_q);
            exp_seq_q   <= seq_no_d + 32'd1;
            exp_valid_q <= 1'b1;
        end
    end

    assign seq_err_cnt = seq_err_q;
`endif

endmodule

// File: tb/tb_txstream.sv
// tb/tb_txstream.sv - directed table-driven bench for the TX IQ stream parser
module tb_txstream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b1;
    logic        have_ip = 1'b1;
    logic        udp_rx_active = 1'b0;
    logic [7:0]  udp_rx_data = 8'd0;
    logic [15:0] udp_to_port = 16'd0;
    logic [47:0] tx_data;
    logic        tx_wrreq;
    logic        tx_wrfull = 1'b0;
    logic [31:0] seq_no;
    logic [15:0] overflow_cnt;
`ifdef SEQ_CHECK_EN
    logic [15:0] seq_err_cnt;
`endif

    txstream dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .have_ip      (have_ip),
        .udp_rx_active(udp_rx_active),
        .udp_rx_data  (udp_rx_data),
        .udp_to_port  (udp_to_port),
        .tx_data      (tx_data),
        .tx_wrreq     (tx_wrreq),
        .tx_wrfull    (tx_wrfull),
        .seq_no       (seq_no),
        .overflow_cnt (overflow_cnt)
`ifdef SEQ_CHECK_EN
        ,
        .seq_err_cnt  (seq_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] port;
        logic [31:0] seq;
        int          nbytes;
        int          flo;
        int          fhi;
        int          exp_wr;
        logic [31:0] exp_seq;
        logic [15:0] exp_ovf;
    } vec_t;

    vec_t        vecs[6];
    logic [47:0] exp_q[$];
    int          total = 0;
    int          passed = 0;
    int          wr_count = 0;
    int          data_err = 0;
    int          consec_err = 0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (tx_wrreq) begin
            wr_count++;
            if (prev_wr) consec_err++;
            if (exp_q.size() == 0) data_err++;
            else if (exp_q.pop_front() !== tx_data) data_err++;
        end
        prev_wr = tx_wrreq;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [47:0] sample_of(input int s);
        logic [23:0] v;
        v = s[23:0];
        return {v, ~v};
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] seq, input int i);
        logic [47:0] w;
        int          b;
        if (i < 4) return seq[31-8*i -: 8];
        w = sample_of((i - 4) / 6);
        b = (i - 4) % 6;
        return w[47-8*b -: 8];
    endfunction

    task automatic send_packet(input logic [15:0] port, input logic [31:0] seq,
                               input int nbytes, input int flo, input int fhi);
        int s;
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            udp_rx_active = 1'b1;
            udp_to_port   = port;
            udp_rx_data   = byte_of(seq, i);
            tx_wrfull     = 1'b0;
            if (i >= 4) begin
                s = (i - 4) / 6;
                tx_wrfull = (s >= flo) && (s <= fhi);
                if (((i - 4) % 6 == 5) && !tx_wrfull && port == 16'd1025 && i < 1030)
                    exp_q.push_back(sample_of(s));
            end
        end
        @(posedge clk); #1;
        udp_rx_active = 1'b0;
        tx_wrfull     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_count = 0;
        data_err = 0;
    endtask

    task automatic check_pkt(input string nm, input int exp_wr,
                             input logic [31:0] exp_seq, input logic [15:0] exp_ovf);
        chk({nm, "_writes"}, 64'(wr_count), 64'(exp_wr));
        chk({nm, "_seq_no"}, 64'(seq_no), 64'(exp_seq));
        chk({nm, "_overflow"}, 64'(overflow_cnt), 64'(exp_ovf));
        chk({nm, "_data_err"}, 64'(data_err), 64'd0);
    endtask

    initial begin
        vecs[0] = '{16'd1025, 32'h0000_0007, 1030, -1, -1, 171, 32'h0000_0007, 16'd0};
        vecs[1] = '{16'd1024, 32'h0000_0055, 1030, -1, -1,   0, 32'h0000_0007, 16'd0};
        vecs[2] = '{16'd1025, 32'h0000_0008, 1030, 10, 19, 161, 32'h0000_0008, 16'd10};
        vecs[3] = '{16'd1025, 32'h0000_0009,   37, -1, -1,   5, 32'h0000_0009, 16'd10};
        vecs[4] = '{16'd1025, 32'h0000_000A, 1030, -1, -1, 171, 32'h0000_000A, 16'd10};
        vecs[5] = '{16'd1025, 32'h0000_000B, 1040, -1, -1, 171, 32'h0000_000B, 16'd10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_data", 64'(tx_data), 64'd0);
        chk("reset_tx_wrreq", 64'(tx_wrreq), 64'd0);
        chk("reset_seq_no", 64'(seq_no), 64'd0);
        chk("reset_overflow", 64'(overflow_cnt), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            clear_counts();
            send_packet(vecs[k].port, vecs[k].seq, vecs[k].nbytes, vecs[k].flo, vecs[k].fhi);
            check_pkt($sformatf("vec%0d", k), vecs[k].exp_wr, vecs[k].exp_seq, vecs[k].exp_ovf);
        end

        // run falls on the cycle the third sample's write is pending: that write still lands
        clear_counts();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            udp_rx_active = 1'b1;
            udp_to_port   = 16'd1025;
            udp_rx_data   = byte_of(32'h0000_0012, i);
            run           = (i < 22);
            if (i >= 4 && i < 22 && ((i - 4) % 6 == 5)) exp_q.push_back(sample_of((i - 4) / 6));
        end
        @(posedge clk); #1;
        udp_rx_active = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run = 1'b1;
        chk("abort_writes", 64'(wr_count), 64'd3);
        chk("abort_seq_no", 64'(seq_no), 64'h12);
        chk("abort_data_err", 64'(data_err), 64'd0);

        // asynchronous reset in the middle of a packet
        for (int i = 0; i < 41; i++) begin
            @(posedge clk); #1;
            udp_rx_active = 1'b1;
            udp_to_port   = 16'd1025;
            udp_rx_data   = byte_of(32'h0000_0020, i);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_tx_data", 64'(tx_data), 64'd0);
        chk("midrst_tx_wrreq", 64'(tx_wrreq), 64'd0);
        chk("midrst_seq_no", 64'(seq_no), 64'd0);
        chk("midrst_overflow", 64'(overflow_cnt), 64'd0);
        exp_q.delete();
        udp_rx_active = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();
        send_packet(16'd1025, 32'h0000_0021, 1030, -1, -1);
        check_pkt("after_rst", 171, 32'h0000_0021, 16'd0);

`ifdef SEQ_CHECK_EN
        run = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        send_packet(16'd1025, 32'd1, 4, -1, -1);
        send_packet(16'd1025, 32'd2, 4, -1, -1);
        send_packet(16'd1025, 32'd4, 4, -1, -1);
        chk("seq_err_after_gap", 64'(seq_err_cnt), 64'd1);
        run = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        send_packet(16'd1025, 32'd9, 4, -1, -1);
        chk("seq_err_after_rerun", 64'(seq_err_cnt), 64'd1);
`endif

        chk("no_consecutive_wrreq", 64'(consec_err), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
